// File: rtl/seq_counter_gen.sv
// Parametrised sequence counter: binary index with a run-time selectable output
// mapping (binary, Gray, XOR-mask), plus enable, direction, load and wrap pulse.
module seq_counter_gen #(
    parameter int               WIDTH = 3,
    parameter logic [WIDTH-1:0] MASK  = WIDTH'(3'b101)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] index,
    output logic             wrap,
    output logic             mode_err
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] index_reg;
    logic [WIDTH-1:0] state_reg;
    logic             wrap_reg;
    logic             mode_err_reg;

    logic [WIDTH-1:0] idx_next;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] state_next;
    logic             wrap_next;
    logic             mode_err_next;

    // Next index: load has priority over stepping; a load never flags a wrap.
    always_comb begin
        idx_next  = index_reg;
        wrap_next = 1'b0;
        if (load) begin
            idx_next = load_val;
        end else if (en) begin
            if (dir) begin
                idx_next  = index_reg - ONE;
                wrap_next = (index_reg == '0);
            end else begin
                idx_next  = index_reg + ONE;
                wrap_next = (index_reg == ALL_ONES);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
            assign gray_next[gi] = idx_next[gi] ^ idx_next[gi+1];
        end
    endgenerate
    assign gray_next[WIDTH-1] = idx_next[WIDTH-1];

    // The mapping is applied to the index being written, so state and index
    // always describe the same step.
    always_comb begin
        state_next    = idx_next;
        mode_err_next = 1'b0;
        case (mode)
            2'd0:    state_next = idx_next;
            2'd1:    state_next = gray_next;
            2'd2:    state_next = idx_next ^ MASK;
            default: begin
                state_next    = idx_next;
                mode_err_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_reg    <= '0;
            state_reg    <= MASK;
            wrap_reg     <= 1'b0;
            mode_err_reg <= 1'b0;
        end else begin
            index_reg    <= idx_next;
            state_reg    <= state_next;
            wrap_reg     <= wrap_next;
            mode_err_reg <= mode_err_next;
        end
    end

    assign index    = index_reg;
    assign state    = state_reg;
    assign wrap     = wrap_reg;
    assign mode_err = mode_err_reg;

endmodule

// File: tb/tb_seq_counter_gen.sv
// Bench for seq_counter_gen: a 3-bit and a 4-bit instance share stimulus and
// are checked every cycle against an arithmetic model, plus literal sequences.
module tb_seq_counter_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       load = 1'b0;
    logic [3:0] lv = 4'd0;
    logic [2:0] lv_a;

    logic [2:0] state_a, index_a;
    logic       wrap_a, err_a;
    logic [3:0] state_b, index_b;
    logic       wrap_b, err_b;

    int tests = 0;
    int fails = 0;

    assign lv_a = lv[2:0];

    always #5 clk = ~clk;

    seq_counter_gen #(.WIDTH(3), .MASK(3'b101)) dut_a (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(lv_a), .state(state_a), .index(index_a), .wrap(wrap_a),
        .mode_err(err_a)
    );

    seq_counter_gen #(.WIDTH(4), .MASK(4'b0101)) dut_b (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .load(load),
        .load_val(lv), .state(state_b), .index(index_b), .wrap(wrap_b),
        .mode_err(err_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ma_idx, ma_st, ma_wr, ma_err;
    int mb_idx, mb_st, mb_wr, mb_err;

    function automatic int map_code(input int n, input int md, input int mask);
        if (md == 1) return n ^ (n >> 1);
        if (md == 2) return n ^ mask;
        return n;
    endfunction

    task automatic step(input int w, input int mask, input int idx,
                        output int idx_o, output int st_o, output int wr_o, output int err_o);
        int size;
        size  = 1 << w;
        idx_o = idx;
        wr_o  = 0;
        if (load) begin
            idx_o = int'(lv) % size;
        end else if (en) begin
            if (dir) begin
                idx_o = (idx + size - 1) % size;
                wr_o  = (idx == 0) ? 1 : 0;
            end else begin
                idx_o = (idx + 1) % size;
                wr_o  = (idx == size - 1) ? 1 : 0;
            end
        end
        st_o  = map_code(idx_o, int'(mode), mask);
        err_o = (mode == 2'd3) ? 1 : 0;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma_idx = 0; ma_st = 5; ma_wr = 0; ma_err = 0;
            mb_idx = 0; mb_st = 5; mb_wr = 0; mb_err = 0;
        end else begin
            step(3, 5, ma_idx, ma_idx, ma_st, ma_wr, ma_err);
            step(4, 5, mb_idx, mb_idx, mb_st, mb_wr, mb_err);
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("a_index", int'(index_a), ma_idx);
        chk("a_state", int'(state_a), ma_st);
        chk("a_wrap", int'(wrap_a), ma_wr);
        chk("a_mode_err", int'(err_a), ma_err);
        chk("b_index", int'(index_b), mb_idx);
        chk("b_state", int'(state_b), mb_st);
        chk("b_wrap", int'(wrap_b), mb_wr);
        chk("b_mode_err", int'(err_b), mb_err);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; en = 1'b0; load = 1'b0; dir = 1'b0; mode = 2'd0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    int xor_seq [8]  = '{4, 7, 6, 1, 0, 3, 2, 5};
    int gray_seq [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        int prev;
        // Reset values
        do_reset();
        chk("rst_index", int'(index_a), 0);
        chk("rst_state", int'(state_a), 5);
        chk("rst_wrap", int'(wrap_a), 0);
        chk("rst_err", int'(err_a), 0);
        $display("[TB] reset values checked");

        // XOR sequence
        mode = 2'd2; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("xor_seq_state", int'(state_a), xor_seq[i]);
            chk("xor_seq_wrap", int'(wrap_a), (i == 7) ? 1 : 0);
        end
        $display("[TB] xor sequence done");

        // Binary count-down from reset
        do_reset();
        mode = 2'd0; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("down_index", int'(index_a), (7 - i + 8) % 8);
            chk("down_state", int'(state_a), (7 - i + 8) % 8);
            chk("down_wrap", int'(wrap_a), (i == 0 || i == 8) ? 1 : 0);
        end
        $display("[TB] binary count-down done");

        // 4-bit Gray sequence
        do_reset();
        mode = 2'd1; en = 1'b1; dir = 1'b0;
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("gray_state", int'(state_b), gray_seq[i]);
            chk("gray_onebit", $countones(int'(state_b) ^ prev), 1);
            prev = int'(state_b);
        end
        $display("[TB] gray sequence done");

        // Load all-ones, then step through the wrap
        mode = 2'd2; load = 1'b1; lv = 4'd7; en = 1'b1; dir = 1'b0;
        @(negedge clk);
        chk("load_index", int'(index_a), 7);
        chk("load_state", int'(state_a), 2);
        chk("load_wrap", int'(wrap_a), 0);
        load = 1'b0;
        @(negedge clk);
        chk("after_load_index", int'(index_a), 0);
        chk("after_load_state", int'(state_a), 5);
        chk("after_load_wrap", int'(wrap_a), 1);
        $display("[TB] load and wrap done");

        // Reserved mode
        mode = 2'd3;
        @(negedge clk);
        chk("m3_state", int'(state_a), 1);
        chk("m3_index", int'(index_a), 1);
        chk("m3_err", int'(err_a), 1);
        mode = 2'd2;
        @(negedge clk);
        chk("m3_clear_err", int'(err_a), 0);
        chk("m3_clear_state", int'(state_a), 7);
        $display("[TB] reserved mode done");

        // Asynchronous reset mid-count at index 4
        do_reset();
        mode = 2'd2; en = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_async_index", int'(index_a), 4);
        #2 rst = 1'b0;
        #1;
        chk("async_index", int'(index_a), 0);
        chk("async_state", int'(state_a), 5);
        chk("async_wrap", int'(wrap_a), 0);

        // Asynchronous reset while a wrap pulse is high
        do_reset();
        mode = 2'd2; en = 1'b1; dir = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_async_wrap", int'(wrap_a), 1);
        #2 rst = 1'b0;
        #1;
        chk("async_wrap_clear", int'(wrap_a), 0);
        $display("[TB] asynchronous reset done");

        // Randomised operation
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            en   = ($urandom_range(0, 3) != 0);
            dir  = $urandom_range(0, 1) == 1;
            mode = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 9) == 0);
            lv   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
        end
        @(negedge clk);
        $display("[TB] randomised run done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_counter_gen.md
Name: seq_counter_gen

Overview:
- Parametrised sequence counter; next generation of the fixed 3-bit sequence counter.
- Holds an internal binary index and outputs a registered mapped code.
- Mapping is selectable at run time: plain binary, Gray, or XOR-mask.
- Adds enable, direction, parallel load, a wrap pulse and a reserved-mode error flag.
- With default parameters and XOR mode, the output sequence is 5,4,7,6,1,0,3,2,5,...

Parameters:
WIDTH, 3, bit width of index and state (legal range 2..16)
MASK, 3'b101 (WIDTH bits), XOR mask for mode 2 and reset value of state

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
en  input  1  advance index by one step this cycle
dir  input  1  0 = increment, 1 = decrement
mode  input  2  0 = binary, 1 = Gray, 2 = XOR-mask, 3 = reserved
load  input  1  load load_val into index this cycle
load_val  input  WIDTH  index value to load
state  output  WIDTH  registered mapped code of the current index
index  output  WIDTH  registered binary index
wrap  output  1  registered one-cycle pulse on index wrap-around
mode_err  output  1  registered; high while mode = 3 was sampled

Behaviour:
- Reset: rst is asynchronous and active-low. Clock clk, rising edge.
- Reset values while rst = 0: index = 0, state = MASK, wrap = 0, mode_err = 0.
- Leaving reset: the first rising edge after rst deasserts applies the normal update rules.
- Next index (idx_n), priority load > en > hold:
  - load = 1: idx_n = load_val (en and dir ignored).
  - else en = 1, dir = 0: idx_n = index + 1, modulo 2^WIDTH.
  - else en = 1, dir = 1: idx_n = index - 1, modulo 2^WIDTH.
  - else: idx_n = index.
- Mapping, applied to idx_n and the mode sampled at the same edge:
  - mode 0: idx_n.
  - mode 1: idx_n ^ (idx_n >> 1).
  - mode 2: idx_n ^ MASK.
  - mode 3: idx_n (binary fallback), and mode_err = 1.
- Every edge: index <= idx_n, state <= map(idx_n, mode), mode_err <= (mode == 3).
- Latency: state and index always correspond to each other; there is no extra pipeline stage.
- A mode change with en = 0 and load = 0 re-maps the unchanged index on the next edge.
- wrap <= 1 only when load = 0 and en = 1 and either:
  - dir = 0 and index = all-ones, or
  - dir = 1 and index = 0.
  - Otherwise wrap <= 0. wrap is therefore exactly one cycle wide per wrap event.
- A load never raises wrap, even when load_val = 0 or all-ones.
- All arithmetic is unsigned WIDTH bits with no carry-out. dir may change on any cycle and takes effect at that edge.
- Reset mid-operation: all outputs go to their reset values immediately, without waiting for clk. Any in-progress wrap pulse is cleared.
- No X propagation: every case of mode, including 3, is defined.

Test Plan:
- Default params, mode = 2, en = 1, dir = 0, 9 clocks after reset:
  - state = 5,4,7,6,1,0,3,2,5.
  - wrap = 1 only on the edge where state returns to 5.
- mode = 0, en = 1, dir = 1 from reset:
  - index = 7,6,5,...,0,7; state equals index.
  - wrap = 1 on the 0 -> 7 edge.
- mode = 1, WIDTH = 4, en = 1, 16 clocks:
  - state = 1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0.
  - Consecutive states differ by exactly one bit.
- load = 1, load_val = 7, en = 1, dir = 0, mode = 2:
  - next edge: index = 7, state = 2, wrap = 0.
  - following edge with load = 0: index = 0, state = 5, wrap = 1.
- mode = 3 with en = 1: state equals index, mode_err = 1. Returning to mode = 2 clears mode_err on the next edge.
- Assert rst = 0 asynchronously mid-count with index = 4: index = 0, state = 5, wrap = 0 immediately, without waiting for clk.
